// File: rtl/da_encode.sv
// rtl/da_encode.sv - 16-bit word to 4-phase nibble serializer with active/hold buffering
module da_encode #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [3:0]    nib,
    output logic [1:0]    phase,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          sof,
    output logic          eof,
    output logic [7:0]    frames
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] active_q, active_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          hold_valid_q, hold_valid_d;
    logic [1:0]    phase_q, phase_d;
    logic [7:0]    frames_q, frames_d;

    logic accept;
    logic transfer;
    logic complete;

    // in_ready depends only on registered state so there is no path from out_ready
    assign in_ready  = ~hold_valid_q;
    assign accept    = in_valid & ~hold_valid_q;
    assign transfer  = (state_q == SEND) & out_ready;
    assign complete  = transfer & (phase_q == 2'd3);

    assign out_valid = (state_q == SEND);
    assign phase     = phase_q;
    assign nib       = out_valid ? active_q[{phase_q, 2'b00} +: 4] : 4'h0;
    assign sof       = out_valid & (phase_q == 2'd0);
    assign eof       = out_valid & (phase_q == 2'd3);
    assign frames    = frames_q;

    // Next-state: phase advance, frame completion with hold/direct reload, word capture
    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        phase_d      = phase_q;
        frames_d     = frames_q;

        if (complete) begin
            phase_d  = 2'd0;
            frames_d = frames_q + 8'd1;
            if (hold_valid_q) begin
                // accept is impossible here because in_ready is low while hold is full
                active_d     = hold_q;
                hold_valid_d = 1'b0;
            end else if (accept) begin
                active_d = in_data;
            end else begin
                state_d = IDLE;
            end
        end else begin
            if (transfer) begin
                phase_d = phase_q + 2'd1;
            end
            if (accept) begin
                if (state_q == IDLE) begin
                    active_d = in_data;
                    state_d  = SEND;
                end else begin
                    hold_d       = in_data;
                    hold_valid_d = 1'b1;
                end
            end
        end
    end

    // State and datapath registers; reset discards all buffered words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            active_q     <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            phase_q      <= 2'd0;
            frames_q     <= 8'd0;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            phase_q      <= phase_d;
            frames_q     <= frames_d;
        end
    end

endmodule

// File: tb/tb_da_encode.sv
// tb/tb_da_encode.sv - directed self-checking bench for da_encode
module tb_da_encode;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  nib;
    logic [1:0]  phase;
    logic        out_valid;
    logic        out_ready;
    logic        sof;
    logic        eof;
    logic [7:0]  frames;

    int n_cmp = 0;
    int n_err = 0;
    int vcnt  = 0;

    da_encode #(.DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .nib       (nib),
        .phase     (phase),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sof       (sof),
        .eof       (eof),
        .frames    (frames)
    );

    always #5 clk = ~clk;

    // Counts cycles with a valid nibble on the output
    always @(negedge clk) begin
        if (out_valid === 1'b1) vcnt <= vcnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [3:0]  exp1 [4]  = '{4'h3, 4'hC, 4'h5, 4'hA};
    logic [15:0] bw   [4]  = '{16'h1234, 16'h5678, 16'h9ABC, 16'h0000};
    logic [3:0]  bexp [12] = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h8, 4'h7, 4'h6, 4'h5,
                               4'hC, 4'hB, 4'hA, 4'h9};
    logic        brdy [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                               1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0]  bp   [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                               4'h9, 4'hA, 4'hB, 4'hC};

    initial begin
        int          wi;
        int          v0;
        int          popped;
        int          cyc;
        bit          acc;
        bit          tr;
        logic [15:0] w;
        logic [3:0]  q[$];
        logic [3:0]  e;

        rst       = 1'b1;
        in_data   = 16'h0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_frames", frames, 0);
        chk("rst_nib", nib, 0);
        chk("rst_phase", phase, 0);
        chk("rst_sof_eof", {sof, eof}, 0);
        rst = 1'b0;
        step();
        chk("idle_out_valid", out_valid, 0);

        // single word
        in_data   = 16'hA5C3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int p = 0; p < 4; p++) begin
            chk("single_valid", out_valid, 1);
            chk("single_phase", phase, p);
            chk("single_nib", nib, exp1[p]);
            chk("single_sof", sof, (p == 0));
            chk("single_eof", eof, (p == 3));
            step();
        end
        chk("single_done_valid", out_valid, 0);
        chk("single_frames", frames, 1);

        // back-to-back with in_valid held
        wi       = 0;
        in_data  = bw[0];
        in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            acc = in_valid && in_ready;
            step();
            if (acc) wi++;
            in_data  = bw[wi];
            in_valid = (wi < 3);
            chk("b2b_valid", out_valid, 1);
            chk("b2b_nib", nib, bexp[c]);
            chk("b2b_in_ready", in_ready, brdy[c]);
        end
        step();
        chk("b2b_done_valid", out_valid, 0);
        chk("b2b_frames", frames, 4);

        // stall during phase 1
        v0       = vcnt;
        in_data  = 16'hFEDC;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("stall_nib0", nib, 4'hC);
        step();
        chk("stall_nib1", nib, 4'hD);
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            chk("stall_hold_nib", nib, 4'hD);
            chk("stall_hold_phase", phase, 1);
            chk("stall_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        step();
        chk("stall_nib2", nib, 4'hE);
        step();
        chk("stall_nib3", nib, 4'hF);
        step();
        chk("stall_done_valid", out_valid, 0);
        chk("stall_vcycles", vcnt - v0, 7);
        chk("stall_frames", frames, 5);

        // backpressure: active + hold fill, third word waits
        out_ready = 1'b0;
        in_data   = 16'h4321;
        in_valid  = 1'b1;
        step();
        chk("bp_rdy_a", in_ready, 1);
        in_data = 16'h8765;
        step();
        chk("bp_rdy_full", in_ready, 0);
        in_data = 16'hCBA9;
        step();
        chk("bp_rdy_full2", in_ready, 0);
        chk("bp_nib_stalled", nib, 4'h1);
        chk("bp_phase_stalled", phase, 0);
        out_ready = 1'b1;
        for (int c = 1; c < 12; c++) begin
            acc = in_valid && in_ready;
            step();
            if (acc) in_valid = 1'b0;
            chk("bp_nib", nib, bp[c]);
            chk("bp_phase", phase, c % 4);
        end
        step();
        chk("bp_done_valid", out_valid, 0);
        chk("bp_frames", frames, 8);

        // reset mid-frame with hold full
        in_data  = 16'h0F0F;
        in_valid = 1'b1;
        step();
        in_data = 16'h1234;
        step();
        in_valid = 1'b0;
        chk("mr_hold_full", in_ready, 0);
        step();
        chk("mr_phase2", phase, 2);
        rst = 1'b1;
        #1;
        chk("mr_async_valid", out_valid, 0);
        chk("mr_async_frames", frames, 0);
        chk("mr_async_ready", in_ready, 1);
        chk("mr_async_nib", nib, 0);
        chk("mr_async_phase", phase, 0);
        chk("mr_async_sofeof", {sof, eof}, 0);
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        step();
        step();
        chk("mr_ignored", out_valid, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("mr_post_valid", out_valid, 0);
            chk("mr_post_frames", frames, 0);
        end

        // 256 frames, frame counter wrap
        wi     = 0;
        popped = 0;
        w      = 16'h0;
        in_data  = 16'h00FF;
        in_valid = 1'b1;
        cyc    = 0;
        while (!(wi == 256 && q.size() == 0) && cyc < 1200) begin
            tr  = (out_valid === 1'b1);
            acc = in_valid && in_ready;
            if (tr) begin
                e = (q.size() > 0) ? q.pop_front() : 4'hx;
                chk("wrap_nib", nib, e);
                popped++;
            end
            if (acc) begin
                for (int k = 0; k < 4; k++) q.push_back(in_data[4*k +: 4]);
            end
            step();
            cyc++;
            if (acc) begin
                wi++;
                w        = 16'(wi);
                in_data  = {w[7:0], ~w[7:0]};
                in_valid = (wi < 256);
            end
            if (tr && popped == 1020) chk("wrap_frames_255", frames, 255);
        end
        chk("wrap_timeout", (cyc < 1200), 1);
        chk("wrap_popped", popped, 1024);
        chk("wrap_frames_0", frames, 0);
        chk("wrap_done_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
